codec_cfg_seq: RTL and testbench

Parametrised register-write sequencer that walks a table of 16-bit configuration words and issues each as an I2C write to one codec device. The table lives in an external ROM, and each word is read as an 8-bit register address plus 8-bit data. The block sits between the audio codec init logic and the I2C master. It adds what a fixed-table sequencer lacks:
- configurable depth,
- device address,
- inter-word settle gap,
- NACK detection with retry,
- explicit done/error status.

---
 rtl/codec_cfg_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_codec_cfg_seq.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_cfg_seq.sv
// ---------------------------------------------------------------------------
// codec_cfg_seq
//
// Walks a table of 16-bit configuration words held in an external ROM and
// issues each one as an I2C register write to a single codec device.  Every
// word is split into an 8-bit register address [15:8] and 8-bit data [7:0].
// A programmable idle gap separates transfers.  A NACKed word can be re-sent
// a bounded number of times.  The run ends in DONE (all words ACKed) or in
// ERROR (unrecoverable NACK).
//
// Optional feature macro: CFG_SEQ_RETRY_EN
//   defined   : a NACKed word is re-fetched and re-sent after the gap, up to
//               MAX_RETRY times, before the run aborts.
//   undefined : no retry counter; the first NACK aborts the run.
//
// Parameters
//   N_WORDS    number of table words sent per run (1..2**ADDR_W)
//   ADDR_W     width of the table index / rom_addr
//   DEV_ADDR   7-bit I2C device address
//   GAP_CYCLES idle clocks between a finished transfer and the next fetch
//   MAX_RETRY  re-sends allowed per word after a NACK
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        begin a run from word 0 (honoured in IDLE, DONE, ERROR)
//   rom_addr     table index presented to the ROM
//   rom_data     ROM word, valid one cycle after rom_addr changes
//   i2c_req      transfer request, held until i2c_busy is seen high
//   i2c_busy     I2C master busy
//   i2c_nack     NACK flag, valid in the cycle i2c_busy falls
//   i2c_dev_addr constant DEV_ADDR
//   i2c_wr_rd    constant 0 (write)
//   i2c_reg_addr latched register address of the current word
//   i2c_data     latched data byte of the current word
//   cfg_busy     sequencer active
//   cfg_done     run completed with every word ACKed
//   cfg_error    run aborted on an unrecoverable NACK
//   err_index    index of the word that failed
// ---------------------------------------------------------------------------
module codec_cfg_seq #(
    parameter int          N_WORDS    = 10,
    parameter int          ADDR_W     = 4,
    parameter logic [6:0]  DEV_ADDR   = 7'h1A,
    parameter int          GAP_CYCLES = 16,
    parameter int          MAX_RETRY  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              i2c_req,
    input  logic              i2c_busy,
    input  logic              i2c_nack,
    output logic [6:0]        i2c_dev_addr,
    output logic              i2c_wr_rd,
    output logic [7:0]        i2c_reg_addr,
    output logic [7:0]        i2c_data,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_error,
    output logic [ADDR_W-1:0] err_index
);

    // The gap counter only has to hold GAP_CYCLES-1.
    localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);

`ifdef CFG_SEQ_RETRY_EN
    localparam int                RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] index;
    logic [GAP_W-1:0]  gap_cnt;

    logic run_clear;
    logic index_inc;
    logic gap_load;
    logic err_capture;

`ifdef CFG_SEQ_RETRY_EN
    logic [RETRY_W-1:0] retry_cnt;
    logic               retry_inc;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath strobes.  A completed transfer either
    // moves on to the next word or re-sends the current one; both paths go
    // through the settle gap, which is skipped entirely when it is zero.
    always_comb begin
        state_next  = state;
        run_clear   = 1'b0;
        index_inc   = 1'b0;
        gap_load    = 1'b0;
        err_capture = 1'b0;
`ifdef CFG_SEQ_RETRY_EN
        retry_inc   = 1'b0;
`endif
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start && !i2c_busy) begin
                    state_next = S_FETCH;
                    run_clear  = 1'b1;
                end
            end
            S_FETCH: state_next = S_LATCH;
            S_LATCH: state_next = S_REQ;
            S_REQ: begin
                if (i2c_busy) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i2c_busy) begin
                    if (!i2c_nack) begin
                        if (index == LAST_IDX) begin
                            state_next = S_DONE;
                        end else begin
                            index_inc  = 1'b1;
                            state_next = (GAP_CYCLES == 0) ? S_FETCH : S_GAP;
                            gap_load   = (GAP_CYCLES != 0);
                        end
`ifdef CFG_SEQ_RETRY_EN
                    end else if (retry_cnt < RETRY_MAX) begin
                        retry_inc  = 1'b1;
                        state_next = (GAP_CYCLES == 0) ? S_FETCH : S_GAP;
                        gap_load   = (GAP_CYCLES != 0);
`endif
                    end else begin
                        err_capture = 1'b1;
                        state_next  = S_ERROR;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Word index, gap counter, latched word and failing-index capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index        <= '0;
            gap_cnt      <= '0;
            i2c_reg_addr <= '0;
            i2c_data     <= '0;
            err_index    <= '0;
        end else begin
            if (run_clear) begin
                index <= '0;
            end else if (index_inc) begin
                index <= index + ADDR_W'(1);
            end

            if (gap_load) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == S_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end

            if (state == S_LATCH) begin
                i2c_reg_addr <= rom_data[15:8];
                i2c_data     <= rom_data[7:0];
            end

            if (err_capture) begin
                err_index <= index;
            end
        end
    end

`ifdef CFG_SEQ_RETRY_EN
    // Retry count is per word: cleared on run start and on every ACK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retry_cnt <= '0;
        end else if (run_clear || index_inc) begin
            retry_cnt <= '0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
        end
    end
`endif

    // Moore outputs decoded from state or driven straight from registers.
    assign rom_addr     = index;
    assign i2c_req      = (state == S_REQ);
    assign i2c_dev_addr = DEV_ADDR;
    assign i2c_wr_rd    = 1'b0;
    assign cfg_busy     = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
    assign cfg_done     = (state == S_DONE);
    assign cfg_error    = (state == S_ERROR);

endmodule

// File: tb/tb_codec_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_codec_cfg_seq
//
// Directed bench for codec_cfg_seq with N_WORDS=3, GAP_CYCLES=4, MAX_RETRY=2
// and a three-word ROM.  A small I2C master model accepts each request, stays
// busy for 20 cycles and answers ACK/NACK from a per-request plan.  Each
// request is logged with its register/data bytes and acceptance cycle.
// Retry-specific scenarios follow CFG_SEQ_RETRY_EN, the same macro as the RTL.
// ---------------------------------------------------------------------------
module tb_codec_cfg_seq;

    localparam int BUSY_CYCLES = 20;
    // Accept-to-accept spacing: busy + fall detect + gap(4) + FETCH + LATCH.
    localparam int WORD_PERIOD = BUSY_CYCLES + 1 + 4 + 1 + 1;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic        i2c_req;
    logic        i2c_busy;
    logic        i2c_nack;
    logic [6:0]  i2c_dev_addr;
    logic        i2c_wr_rd;
    logic [7:0]  i2c_reg_addr;
    logic [7:0]  i2c_data;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_error;
    logic [3:0]  err_index;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    logic [15:0] rom [0:2];
    logic [7:0]  exp_reg  [0:2];
    logic [7:0]  exp_data [0:2];

    // I2C model log and plan.
    int          req_count = 0;
    int          busy_left = 0;
    int          last_fall_cyc = 0;
    logic        pending_nack = 1'b0;
    logic [7:0]  log_reg  [0:15];
    logic [7:0]  log_data [0:15];
    int          log_cyc  [0:15];
    logic        nack_plan[0:15];

    codec_cfg_seq #(
        .N_WORDS   (3),
        .ADDR_W    (4),
        .DEV_ADDR  (7'h1A),
        .GAP_CYCLES(4),
        .MAX_RETRY (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .i2c_req     (i2c_req),
        .i2c_busy    (i2c_busy),
        .i2c_nack    (i2c_nack),
        .i2c_dev_addr(i2c_dev_addr),
        .i2c_wr_rd   (i2c_wr_rd),
        .i2c_reg_addr(i2c_reg_addr),
        .i2c_data    (i2c_data),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_error   (cfg_error),
        .err_index   (err_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    assign rom_data = (rom_addr < 4'd3) ? rom[rom_addr[1:0]] : 16'hDEAD;

    // I2C master model: acts just after each rising edge.
    initial begin
        i2c_busy = 1'b0;
        i2c_nack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                busy_left = 0;
                i2c_busy  = 1'b0;
                i2c_nack  = 1'b0;
            end else if (busy_left > 0) begin
                busy_left = busy_left - 1;
                if (busy_left == 0) begin
                    i2c_busy      = 1'b0;
                    i2c_nack      = pending_nack;
                    last_fall_cyc = cyc;
                end
            end else begin
                i2c_nack = 1'b0;
                if (i2c_req && !i2c_busy && req_count < 16) begin
                    log_reg[req_count]  = i2c_reg_addr;
                    log_data[req_count] = i2c_data;
                    log_cyc[req_count]  = cyc;
                    pending_nack        = nack_plan[req_count];
                    req_count           = req_count + 1;
                    i2c_busy            = 1'b1;
                    busy_left           = BUSY_CYCLES;
                end
            end
        end
    end

    task automatic clear_plan();
        for (int i = 0; i < 16; i++) nack_plan[i] = 1'b0;
        req_count = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_status(input int budget, output bit ok, output int seen_cyc);
        ok = 1'b0;
        seen_cyc = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (cfg_done || cfg_error) begin
                ok = 1'b1;
                seen_cyc = cyc;
            end
        end
    endtask

    task automatic wait_reqs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (req_count >= n) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rom_addr, i2c_req, i2c_reg_addr, i2c_data} !== 21'h0) begin
            n_fails++;
            $display("[TB] FAIL reset_regs: got addr=%0h req=%0b reg=%0h data=%0h expected 0",
                     rom_addr, i2c_req, i2c_reg_addr, i2c_data);
        end
        n_checks++;
        if ({cfg_busy, cfg_done, cfg_error, err_index} !== 7'h0) begin
            n_fails++;
            $display("[TB] FAIL reset_status: got busy=%0b done=%0b err=%0b idx=%0h expected 0",
                     cfg_busy, cfg_done, cfg_error, err_index);
        end
        n_checks++;
        if (i2c_dev_addr !== 7'h1A || i2c_wr_rd !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_const: got dev=%0h wr_rd=%0b expected 1a/0", i2c_dev_addr, i2c_wr_rd);
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (cfg_busy !== 1'b0 || i2c_req !== 1'b0) begin
                n_fails++;
                $display("[TB] FAIL idle_quiet: got busy=%0b req=%0b expected 0/0", cfg_busy, i2c_req);
            end
        end
    endtask

    task automatic test_clean_run();
        bit ok;
        int done_cyc;
        clear_plan();
        pulse_start();
        wait_status(400, ok, done_cyc);
        n_checks++;
        if (!ok || cfg_done !== 1'b1 || cfg_error !== 1'b0 || cfg_busy !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL clean_status: got ok=%0b done=%0b err=%0b busy=%0b expected 1/1/0/0",
                     ok, cfg_done, cfg_error, cfg_busy);
        end
        n_checks++;
        if (req_count !== 3) begin
            n_fails++;
            $display("[TB] FAIL clean_count: got %0d requests expected 3", req_count);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (log_reg[i] !== exp_reg[i] || log_data[i] !== exp_data[i]) begin
                n_fails++;
                $display("[TB] FAIL clean_word%0d: got %0h/%0h expected %0h/%0h",
                         i, log_reg[i], log_data[i], exp_reg[i], exp_data[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (log_cyc[i] - log_cyc[i-1] !== WORD_PERIOD) begin
                n_fails++;
                $display("[TB] FAIL clean_spacing%0d: got %0d cycles expected %0d",
                         i, log_cyc[i] - log_cyc[i-1], WORD_PERIOD);
            end
        end
        n_checks++;
        if (done_cyc - last_fall_cyc !== 1) begin
            n_fails++;
            $display("[TB] FAIL clean_done_latency: got %0d expected 1", done_cyc - last_fall_cyc);
        end
    endtask

    task automatic test_retry();
        bit ok;
        int done_cyc;
        clear_plan();
        nack_plan[1] = 1'b1;
`ifdef CFG_SEQ_RETRY_EN
        nack_plan[2] = 1'b1;
`endif
        pulse_start();
        wait_status(600, ok, done_cyc);
`ifdef CFG_SEQ_RETRY_EN
        n_checks++;
        if (!ok || cfg_done !== 1'b1 || cfg_error !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL retry_status: got ok=%0b done=%0b err=%0b expected 1/1/0", ok, cfg_done, cfg_error);
        end
        n_checks++;
        if (req_count !== 5) begin
            n_fails++;
            $display("[TB] FAIL retry_count: got %0d requests expected 5", req_count);
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (log_reg[i] !== 8'h0C || log_data[i] !== 8'h00) begin
                n_fails++;
                $display("[TB] FAIL retry_word%0d: got %0h/%0h expected 0c/00", i, log_reg[i], log_data[i]);
            end
        end
        n_checks++;
        if (log_reg[4] !== 8'h05 || log_data[4] !== 8'h79) begin
            n_fails++;
            $display("[TB] FAIL retry_last: got %0h/%0h expected 05/79", log_reg[4], log_data[4]);
        end
`else
        n_checks++;
        if (!ok || cfg_error !== 1'b1 || cfg_done !== 1'b0 || err_index !== 4'd1) begin
            n_fails++;
            $display("[TB] FAIL noretry_status: got ok=%0b err=%0b done=%0b idx=%0d expected 1/1/0/1",
                     ok, cfg_error, cfg_done, err_index);
        end
        n_checks++;
        if (req_count !== 2) begin
            n_fails++;
            $display("[TB] FAIL noretry_count: got %0d requests expected 2", req_count);
        end
`endif
    endtask

    task automatic test_exhaustion();
        bit ok;
        int done_cyc;
        int exp_reqs;
        clear_plan();
`ifdef CFG_SEQ_RETRY_EN
        nack_plan[2] = 1'b1;
        nack_plan[3] = 1'b1;
        nack_plan[4] = 1'b1;
        exp_reqs = 5;
`else
        nack_plan[2] = 1'b1;
        exp_reqs = 3;
`endif
        pulse_start();
        wait_status(600, ok, done_cyc);
        n_checks++;
        if (!ok || cfg_error !== 1'b1 || cfg_done !== 1'b0 || err_index !== 4'd2) begin
            n_fails++;
            $display("[TB] FAIL exhaust_status: got ok=%0b err=%0b done=%0b idx=%0d expected 1/1/0/2",
                     ok, cfg_error, cfg_done, err_index);
        end
        repeat (60) @(negedge clk);
        n_checks++;
        if (req_count !== exp_reqs || i2c_req !== 1'b0 || cfg_error !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL exhaust_quiet: got reqs=%0d req=%0b err=%0b expected %0d/0/1",
                     req_count, i2c_req, cfg_error, exp_reqs);
        end
    endtask

    task automatic test_start_handling();
        bit ok;
        int done_cyc;
        clear_plan();
        pulse_start();
        wait_reqs(1, 50, ok);
        repeat (5) @(negedge clk);
        pulse_start();
        wait_status(400, ok, done_cyc);
        n_checks++;
        if (!ok || cfg_done !== 1'b1 || cfg_error !== 1'b0 || req_count !== 3) begin
            n_fails++;
            $display("[TB] FAIL start_ignored: got ok=%0b done=%0b err=%0b reqs=%0d expected 1/1/0/3",
                     ok, cfg_done, cfg_error, req_count);
        end
        n_checks++;
        if (log_reg[1] !== 8'h0C || log_reg[2] !== 8'h05) begin
            n_fails++;
            $display("[TB] FAIL start_ignored_order: got %0h,%0h expected 0c,05", log_reg[1], log_reg[2]);
        end
        clear_plan();
        pulse_start();
        wait_reqs(1, 50, ok);
        n_checks++;
        if (!ok || log_reg[0] !== 8'h1E || log_data[0] !== 8'h00) begin
            n_fails++;
            $display("[TB] FAIL restart_word0: got ok=%0b %0h/%0h expected 1 1e/00", ok, log_reg[0], log_data[0]);
        end
        n_checks++;
        if (cfg_done !== 1'b0 || cfg_busy !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL restart_status: got done=%0b busy=%0b expected 0/1", cfg_done, cfg_busy);
        end
        wait_status(400, ok, done_cyc);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int done_cyc;
        clear_plan();
        pulse_start();
        wait_reqs(2, 100, ok);
        repeat (5) @(negedge clk);
        n_checks++;
        if (!ok || i2c_reg_addr !== 8'h0C || rom_addr !== 4'd1) begin
            n_fails++;
            $display("[TB] FAIL midreset_setup: got ok=%0b reg=%0h addr=%0d expected 1/0c/1", ok, i2c_reg_addr, rom_addr);
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({rom_addr, i2c_req, i2c_reg_addr, i2c_data} !== 21'h0 ||
            {cfg_busy, cfg_done, cfg_error} !== 3'b000) begin
            n_fails++;
            $display("[TB] FAIL midreset_outputs: got addr=%0d req=%0b reg=%0h data=%0h busy=%0b done=%0b err=%0b expected all 0",
                     rom_addr, i2c_req, i2c_reg_addr, i2c_data, cfg_busy, cfg_done, cfg_error);
        end
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_plan();
        pulse_start();
        wait_reqs(1, 50, ok);
        n_checks++;
        if (!ok || log_reg[0] !== 8'h1E || log_data[0] !== 8'h00) begin
            n_fails++;
            $display("[TB] FAIL midreset_restart: got ok=%0b %0h/%0h expected 1 1e/00", ok, log_reg[0], log_data[0]);
        end
        wait_status(400, ok, done_cyc);
        n_checks++;
        if (!ok || cfg_done !== 1'b1 || req_count !== 3) begin
            n_fails++;
            $display("[TB] FAIL midreset_finish: got ok=%0b done=%0b reqs=%0d expected 1/1/3", ok, cfg_done, req_count);
        end
    endtask

    initial begin
        rom[0] = 16'h1E00;
        rom[1] = 16'h0C00;
        rom[2] = 16'h0579;
        exp_reg[0]  = 8'h1E; exp_data[0] = 8'h00;
        exp_reg[1]  = 8'h0C; exp_data[1] = 8'h00;
        exp_reg[2]  = 8'h05; exp_data[2] = 8'h79;
        for (int i = 0; i < 16; i++) nack_plan[i] = 1'b0;
        reset_n = 1'b0;
        start   = 1'b0;

        test_reset();
        test_clean_run();
        test_retry();
        test_exhaustion();
        test_start_handling();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
